// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/done handshake and result bus between the binary source and the BCD converter
interface bin2bcd_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] bin;
  logic busy;
  logic done;
  logic [31:0] bcd;
  logic neg;
  logic ovf;
  modport master(output start, bin, input busy, done, bcd, neg, ovf);
  modport slave(input start, bin, output busy, done, bcd, neg, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter from a WIDTH-bit binary word to 8 packed BCD digits
module bin2bcd_seq #(
  parameter int WIDTH = 32,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst,
  bin2bcd_if.slave io
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, mag;
  logic [39:0] acc_q, acc_d;
  logic [35:0] acc_adj;
  logic [5:0] cnt_q, cnt_d;
  logic neg_r_q, neg_r_d, busy_q, busy_d, done_q, done_d, neg_q, neg_d, ovf_q, ovf_d;
  logic [31:0] bcd_q, bcd_d;
  logic is_neg, go, shift;
  genvar i;
  for (i = 0; i < 9; i++) begin : g_adj
    assign acc_adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_r_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_r_q <= neg_r_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
      neg_q <= neg_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    is_neg = SIGNED && io.bin[WIDTH-1];
    mag = is_neg ? -io.bin : io.bin;
    go = (state_q == IDLE) && io.start;
    shift = state_q == SHIFT;
    state_d = go ? SHIFT : shift ? (cnt_q == 6'd1 ? DONE : SHIFT) : IDLE;
    sh_d = go ? mag : shift ? sh_q << 1 : sh_q;
    acc_d = go ? '0 : shift ? {acc_q[38:36], acc_adj, sh_q[WIDTH-1]} : acc_q;
    cnt_d = go ? 6'(WIDTH) : shift ? cnt_q - 6'd1 : cnt_q;
    neg_r_d = go ? is_neg : neg_r_q;
  end
  always_comb begin
    busy_d = state_d != IDLE;
    done_d = state_q == DONE;
    bcd_d = done_d ? acc_q[31:0] : bcd_q;
    ovf_d = done_d ? |acc_q[39:32] : ovf_q;
    neg_d = done_d ? neg_r_q : neg_q;
  end
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bcd = bcd_q;
  assign io.neg = neg_q;
  assign io.ovf = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for unsigned and signed bin2bcd_seq instances
module tb_bin2bcd_seq;
  logic clk, rst;
  int checks = 0, errors = 0;
  int lat, bcnt, t, t1, dn;
  bin2bcd_if #(.WIDTH(32)) ui ();
  bin2bcd_if #(.WIDTH(32)) si ();
  bin2bcd_seq #(.WIDTH(32), .SIGNED(1'b0)) u_dut (.clk(clk), .rst(rst), .io(ui));
  bin2bcd_seq #(.WIDTH(32), .SIGNED(1'b1)) s_dut (.clk(clk), .rst(rst), .io(si));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic convert(input bit s, input logic [31:0] v, output int l, output int b);
    @(negedge clk);
    if (s) begin si.start = 1'b1; si.bin = v; end
    else begin ui.start = 1'b1; ui.bin = v; end
    @(posedge clk); #1;
    ui.start = 1'b0;
    si.start = 1'b0;
    b = (s ? si.busy : ui.busy) ? 1 : 0;
    l = 0;
    do begin
      @(posedge clk); #1;
      l++;
      if (s ? si.busy : ui.busy) b++;
    end while (!(s ? si.done : ui.done) && l < 100);
  endtask
  task automatic check_out(input bit s, input string tag, input logic [31:0] eb, input logic en, input logic eo);
    chk({tag, "_bcd"}, s ? si.bcd : ui.bcd, eb);
    chk({tag, "_neg"}, {31'd0, s ? si.neg : ui.neg}, {31'd0, en});
    chk({tag, "_ovf"}, {31'd0, s ? si.ovf : ui.ovf}, {31'd0, eo});
  endtask
  initial begin
    rst = 1'b1;
    ui.start = 1'b0; ui.bin = '0;
    si.start = 1'b0; si.bin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, ui.busy}, 32'd0);
    chk("rst_done", {31'd0, ui.done}, 32'd0);
    check_out(1'b0, "rst", 32'h0, 1'b0, 1'b0);
    check_out(1'b1, "rst_s", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    convert(1'b0, 32'd12345678, lat, bcnt);
    chk("lat_12345678", lat, 33);
    chk("busy_cycles", bcnt, 33);
    check_out(1'b0, "u12345678", 32'h12345678, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, ui.done}, 32'd0);
    chk("bcd_hold", ui.bcd, 32'h12345678);
    convert(1'b0, 32'hFFFF_FFFF, lat, bcnt);
    check_out(1'b0, "u_max", 32'h94967295, 1'b0, 1'b1);
    convert(1'b0, 32'h0, lat, bcnt);
    check_out(1'b0, "u_zero", 32'h0, 1'b0, 1'b0);
    convert(1'b1, 32'hFFFF_FFFF, lat, bcnt);
    chk("lat_signed", lat, 33);
    check_out(1'b1, "s_m1", 32'h00000001, 1'b1, 1'b0);
    convert(1'b1, 32'h8000_0000, lat, bcnt);
    check_out(1'b1, "s_min", 32'h47483648, 1'b1, 1'b1);
    convert(1'b1, 32'd0, lat, bcnt);
    check_out(1'b1, "s_zero", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    ui.start = 1'b1; ui.bin = 32'd99;
    @(posedge clk); #1;
    ui.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    ui.start = 1'b1; ui.bin = 32'd7;
    dn = 0;
    @(posedge clk); #1;
    ui.start = 1'b0; ui.bin = 32'd0;
    repeat (45) begin
      @(posedge clk); #1;
      if (ui.done) dn++;
    end
    chk("ignore_done_count", dn, 1);
    chk("ignore_bcd", ui.bcd, 32'h00000099);
    @(negedge clk);
    ui.start = 1'b1; ui.bin = 32'd42;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!ui.done && t < 200);
    t1 = t;
    chk("held_bcd42", ui.bcd, 32'h00000042);
    ui.bin = 32'd43;
    do begin @(posedge clk); #1; t++; end while (!ui.done && t < 400);
    ui.start = 1'b0;
    chk("held_spacing", t - t1, 34);
    chk("held_bcd43", ui.bcd, 32'h00000043);
    convert(1'b0, 32'd12345678, lat, bcnt);
    chk("pre_rst_bcd", ui.bcd, 32'h12345678);
    @(negedge clk);
    ui.start = 1'b1; ui.bin = 32'd999;
    @(posedge clk); #1;
    ui.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, ui.busy}, 32'd0);
    chk("midrst_done", {31'd0, ui.done}, 32'd0);
    chk("midrst_bcd", ui.bcd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ui.done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_bcd_hold", ui.bcd, 32'h0);
    convert(1'b0, 32'd5, lat, bcnt);
    chk("post_rst_lat", lat, 33);
    check_out(1'b0, "post_rst", 32'h00000005, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
